// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock: pulses the PLL
// reset, waits for synchronized lock, and holds the system reset until lock is stable.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABILIZE = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_sync1;
  logic          r_locked_s;
  logic [7:0]    r_retry;
  logic [7:0]    w_retry_nxt;
  logic          r_pll_rst;
  logic          r_sys_rst;
  logic          r_ready;
  logic          r_lock_lost;
  logic          w_lock_lost_nxt;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CW'(1);
    w_retry_nxt     = r_retry;
    w_lock_lost_nxt = 1'b0;
    case (r_state)
      ST_PLL_RESET: begin
        if (r_cnt == PR_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock seen on the timeout cycle takes priority over a retry.
        if (r_locked_s) begin
          w_state_nxt = ST_STABILIZE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = ST_PLL_RESET;
          w_cnt_nxt   = '0;
          if (r_retry != 8'hFF) w_retry_nxt = r_retry + 8'd1;
        end
      end
      ST_STABILIZE: begin
        if (!r_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == ST_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (!r_locked_s) begin
          w_state_nxt     = ST_PLL_RESET;
          w_lock_lost_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_PLL_RESET;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= ST_PLL_RESET;
      r_cnt       <= '0;
      r_sync1     <= 1'b0;
      r_locked_s  <= 1'b0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sync1     <= locked;
      r_locked_s  <= r_sync1;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= (w_state_nxt == ST_PLL_RESET);
      r_sys_rst   <= (w_state_nxt != ST_RUN);
      r_ready     <= (w_state_nxt == ST_RUN);
      r_lock_lost <= w_lock_lost_nxt;
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboarded bench for pll_reset_sequencer: a cycle model queues expected outputs
// per driven cycle; scenario checks measure pulse widths and lock latencies directly.
module tb_pll_reset_sequencer;

  localparam int unsigned PRC = 4;
  localparam int unsigned TOC = 20;
  localparam int unsigned STC = 8;

  localparam int M_PR = 0;
  localparam int M_WL = 1;
  localparam int M_ST = 2;
  localparam int M_RN = 3;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (PRC),
    .LOCK_TIMEOUT_CYCLES(TOC),
    .LOCK_STABLE_CYCLES (STC)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  always #10 refclk = ~refclk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [11:0] exp_q[$];

  int          m_state = M_PR;
  int unsigned m_cnt   = 0;
  logic        m_s1    = 1'b0;
  logic        m_s2    = 1'b0;
  logic [7:0]  m_retry = 8'd0;
  logic        m_ll    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance the reference model by one edge with the given inputs.
  task automatic model_edge(input logic r, input logic lk);
    logic ls;
    if (r) begin
      m_state = M_PR; m_cnt = 0; m_s1 = 1'b0; m_s2 = 1'b0; m_retry = 8'd0; m_ll = 1'b0;
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      m_ll = 1'b0;
      case (m_state)
        M_PR: if (m_cnt == PRC - 1) begin m_state = M_WL; m_cnt = 0; end else m_cnt++;
        M_WL: begin
          if (ls) begin m_state = M_ST; m_cnt = 0; end
          else if (m_cnt == TOC - 1) begin
            m_state = M_PR; m_cnt = 0;
            if (m_retry != 8'hFF) m_retry = m_retry + 8'd1;
          end else m_cnt++;
        end
        M_ST: begin
          if (!ls) begin m_state = M_WL; m_cnt = 0; end
          else if (m_cnt == STC - 1) begin m_state = M_RN; m_cnt = 0; end
          else m_cnt++;
        end
        default: if (!ls) begin m_state = M_PR; m_cnt = 0; m_ll = 1'b1; end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic lk);
    logic [11:0] e;
    rst    = r;
    locked = lk;
    model_edge(r, lk);
    exp_q.push_back({(m_state == M_PR), (m_state != M_RN), (m_state == M_RN), m_ll, m_retry});
    @(posedge refclk);
    #1;
    e = exp_q.pop_front();
    chk("outputs", 32'({pll_rst, sys_rst, ready, lock_lost, retry_count}), 32'(e));
    chk("inv_ready_sysrst", 32'(ready), 32'(!sys_rst));
    chk("inv_pll_and_ready", 32'(pll_rst & ready), 32'd0);
  endtask

  task automatic drop_to_wait();
    int n;
    n = 0;
    while (!lock_lost && n < 20) begin step(1'b0, 1'b0); n++; end
    while (pll_rst && n < 60) begin step(1'b0, 1'b0); n++; end
  endtask

  initial begin
    int n;
    #5;
    // Power-up
    repeat (3) step(1'b1, 1'b0);
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_sys_rst", 32'(sys_rst), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
    chk("rst_retry", 32'(retry_count), 32'd0);
    n = 0;
    do begin step(1'b0, 1'b0); n++; end while (pll_rst && n < 40);
    chk("pll_rst_len", 32'(n), 32'(PRC));
    chk("sys_rst_hold", 32'(sys_rst), 32'd1);

    // Clean lock from the first WAIT_LOCK edge
    n = 0;
    do begin step(1'b0, 1'b1); n++; end while (!ready && n < 100);
    chk("lock_edges", 32'(n), 32'd11);
    chk("run_sys_rst", 32'(sys_rst), 32'd0);

    // Loss of lock in RUN
    n = 0;
    do begin step(1'b0, 1'b0); n++; end while (!lock_lost && n < 20);
    chk("loss_edges", 32'(n), 32'd3);
    chk("loss_pll_rst", 32'(pll_rst), 32'd1);
    chk("loss_sys_rst", 32'(sys_rst), 32'd1);
    chk("loss_ready", 32'(ready), 32'd0);
    n = 0;
    do begin
      step(1'b0, 1'b0); n++;
      if (n == 1) chk("lock_lost_pulse", 32'(lock_lost), 32'd0);
    end while (pll_rst && n < 40);
    chk("loss_pll_rst_len", 32'(n), 32'(PRC));
    chk("loss_no_retry", 32'(retry_count), 32'd0);
    n = 0;
    do begin step(1'b0, 1'b1); n++; end while (!ready && n < 100);
    chk("relock_edges", 32'(n), 32'd11);

    // One-cycle glitch at stable count 5
    drop_to_wait();
    repeat (8) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    n = 0;
    do begin step(1'b0, 1'b1); n++; end while (!ready && n < 100);
    chk("glitch_ready_edges", 32'(n), 32'd11);
    chk("glitch_no_retry", 32'(retry_count), 32'd0);

    // Lock timeouts
    drop_to_wait();
    n = 0;
    do begin step(1'b0, 1'b0); n++; end while (!pll_rst && n < 100);
    chk("timeout_len", 32'(n), 32'(TOC));
    chk("retry_1", 32'(retry_count), 32'd1);
    for (int k = 2; k <= 3; k++) begin
      n = 0;
      do begin step(1'b0, 1'b0); n++; end while (pll_rst && n < 100);
      do begin step(1'b0, 1'b0); n++; end while (!pll_rst && n < 200);
      chk("timeout_period", 32'(n), 32'(PRC + TOC));
      chk("retry_inc", 32'(retry_count), 32'(k));
    end

    // Lock seen exactly on the timeout cycle
    n = 0;
    while (pll_rst && n < 40) begin step(1'b0, 1'b0); n++; end
    repeat (17) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    chk("edge_lock_pll_rst", 32'(pll_rst), 32'd0);
    chk("edge_lock_retry", 32'(retry_count), 32'd3);
    repeat (STC - 1) step(1'b0, 1'b1);
    chk("edge_lock_not_ready", 32'(ready), 32'd0);
    step(1'b0, 1'b1);
    chk("edge_lock_ready", 32'(ready), 32'd1);

    // rst mid-STABILIZE
    drop_to_wait();
    repeat (6) step(1'b0, 1'b1);
    chk("pre_abort_sys_rst", 32'(sys_rst), 32'd1);
    step(1'b1, 1'b1);
    chk("abort_pll_rst", 32'(pll_rst), 32'd1);
    chk("abort_sys_rst", 32'(sys_rst), 32'd1);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_lock_lost", 32'(lock_lost), 32'd0);
    chk("abort_retry", 32'(retry_count), 32'd0);

    // Retry counter saturation over 300 timeouts
    n = 0;
    while (retry_count != 8'd255 && n < 300 * 24) begin step(1'b0, 1'b0); n++; end
    chk("sat_reach", 32'(retry_count), 32'd255);
    chk("sat_steps", 32'(n), 32'(255 * (PRC + TOC)));
    repeat (45 * (PRC + TOC)) step(1'b0, 1'b0);
    chk("sat_hold", 32'(retry_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
